shift_register_sequencer: RTL and testbench

Controller that sequences a `shift_register` instance as a serial-to-parallel deserializer. It accepts a serial bit stream through a valid/ready handshake and drives the register's reset, advance and bit inputs. It counts WIDTH bits, then presents the assembled word on a valid/ready output port. It also handles abort, an inter-bit idle timeout and backpressure, and sits between a serial front end and word-level consumers.

---
 rtl/shift_register_sequencer.sv | 137 +++++++++++++
 tb/tb_shift_register_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_sequencer.sv
// Sequences an external shift register as a serial-to-parallel deserializer (MSB first).
// Latency: word_valid_o rises the cycle after the WIDTH-th accepted bit; WIDTH+1 cycles/word streaming.
// Backpressure: FULL holds the word (in_ready_o=0) until word_ready_i; abort_i drops everything.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_valid_i/in_bit_i      serial bit input, in_ready_o accepts it
//   abort_i                  discard partial or complete word, restart via CLEAR
//   sr_rst_o/sr_advance_o    control of the attached shift register (sync clear / shift)
//   sr_bit_o, sr_value_i     bit fed into, and parallel value read back from, the register
//   word_valid_o/word_ready_i/word_o   assembled word output handshake
//   count_o                  bits accepted into the current word (saturates at WIDTH)
//   timeout_o                one-cycle pulse in the CLEAR cycle caused by an idle timeout
module shift_register_sequencer #(
  parameter int WIDTH   = 8,   // word length, >= 2, equal to the register's WIDTH
  parameter int TIMEOUT = 0    // idle cycles tolerated inside a partial word, 0 = never
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  input  logic                       in_bit_i,
  output logic                       in_ready_o,
  input  logic                       abort_i,
  output logic                       sr_rst_o,
  output logic                       sr_advance_o,
  output logic                       sr_bit_o,
  input  logic [WIDTH-1:0]           sr_value_i,
  output logic                       word_valid_o,
  input  logic                       word_ready_i,
  output logic [WIDTH-1:0]           word_o,
  output logic [$clog2(WIDTH+1)-1:0] count_o,
  output logic                       timeout_o
);

  localparam int CW = $clog2(WIDTH + 1);
  // Idle counter only has to reach TIMEOUT-1.
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idle_q,  idle_d;
  logic          timeout_q, timeout_d;
  logic          accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_CLEAR;
      count_q   <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idle_d       = '0;      // idle only survives while a partial word waits in SHIFT
    timeout_d    = 1'b0;
    in_ready_o   = 1'b0;
    word_valid_o = 1'b0;
    sr_rst_o     = 1'b0;
    sr_advance_o = 1'b0;
    accept       = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        // Single cycle: wipe the register so a discarded word leaves no stale bits.
        sr_rst_o = 1'b1;
        state_d  = ST_SHIFT;
        count_d  = '0;
      end

      ST_SHIFT: begin
        in_ready_o   = ~abort_i;
        accept       = in_valid_i & ~abort_i;
        sr_advance_o = accept;
        if (accept) begin
          count_d = count_q + CW'(1);
          // SHIFT is left at WIDTH-1, so the count can never pass WIDTH.
          if (count_q == LAST_BIT) begin
            state_d = ST_FULL;
          end
        end else if ((TIMEOUT > 0) && (count_q != '0)) begin
          // An empty word may wait forever; only a started word can go stale.
          if (idle_q == IDLE_LAST) begin
            state_d   = ST_CLEAR;
            count_d   = '0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
      end

      ST_FULL: begin
        word_valid_o = ~abort_i;
        // in_ready_o stays 0 here, so word_ready_i never reaches it combinationally.
        if (~abort_i & word_ready_i) begin
          // No clear needed: the next WIDTH shifts overwrite every bit.
          state_d = ST_SHIFT;
          count_d = '0;
        end
      end

      default: begin
        state_d = ST_CLEAR;
        count_d = '0;
      end
    endcase

    // Abort wins over accept and word handshake; a coincident timeout still pulses.
    if (abort_i) begin
      state_d = ST_CLEAR;
      count_d = '0;
      idle_d  = '0;
    end
  end

  assign sr_bit_o  = in_bit_i;
  assign word_o    = sr_value_i;
  assign count_o   = count_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench: two sequencers (TIMEOUT=4 and TIMEOUT=0) share one stimulus, each with its own
// shift register stand-in; a cycle model is compared every cycle plus literal spot checks.
module tb_shift_register_sequencer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic abort = 1'b0;
  logic word_ready = 1'b1;

  logic         in_ready [2];
  logic         sr_rst [2];
  logic         sr_adv [2];
  logic         sr_bit [2];
  logic         word_valid [2];
  logic         tmo_pulse [2];
  logic [W-1:0] sr_val [2];
  logic [W-1:0] word [2];
  logic [3:0]   cnt [2];

  int total = 0;
  int bad = 0;
  int tmo_cfg [2] = '{4, 0};

  always #5 clk = ~clk;

  shift_register_sequencer #(.WIDTH(W), .TIMEOUT(4)) dut_t4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_bit_i(in_bit),
    .in_ready_o(in_ready[0]), .abort_i(abort), .sr_rst_o(sr_rst[0]),
    .sr_advance_o(sr_adv[0]), .sr_bit_o(sr_bit[0]), .sr_value_i(sr_val[0]),
    .word_valid_o(word_valid[0]), .word_ready_i(word_ready), .word_o(word[0]),
    .count_o(cnt[0]), .timeout_o(tmo_pulse[0]));

  shift_register_sequencer #(.WIDTH(W), .TIMEOUT(0)) dut_t0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_bit_i(in_bit),
    .in_ready_o(in_ready[1]), .abort_i(abort), .sr_rst_o(sr_rst[1]),
    .sr_advance_o(sr_adv[1]), .sr_bit_o(sr_bit[1]), .sr_value_i(sr_val[1]),
    .word_valid_o(word_valid[1]), .word_ready_i(word_ready), .word_o(word[1]),
    .count_o(cnt[1]), .timeout_o(tmo_pulse[1]));

  // Shift register stand-ins: synchronous clear, shift left inserting at the LSB.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sr_rst[k]) sr_val[k] <= '0;
      else if (sr_adv[k]) sr_val[k] <= {sr_val[k][W-2:0], sr_bit[k]};
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] at %0t: got %0h want %0h", nm, k, $time, act, exp);
    end
  endtask

  // Model: m_n = -1 while clearing, 0..W-1 bits gathered, W when a word is held.
  int           m_n [2] = '{-1, -1};
  int           m_idle [2] = '{0, 0};
  logic         m_to [2] = '{1'b0, 1'b0};
  logic [W-1:0] m_word [2];
  bit           shifting, take, fire;
  int           nxt;

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_n[k] = -1;
        m_idle[k] = 0;
        m_to[k] = 1'b0;
      end else begin
        shifting = (m_n[k] >= 0) && (m_n[k] < W);
        take = shifting && in_valid && !abort;
        nxt = m_n[k];
        fire = 1'b0;
        if (m_n[k] < 0) begin
          nxt = 0;
        end else if (take) begin
          m_word[k] = {m_word[k][W-2:0], in_bit};
          nxt = m_n[k] + 1;
          m_idle[k] = 0;
        end else if (shifting) begin
          if (m_n[k] > 0 && tmo_cfg[k] > 0) begin
            m_idle[k]++;
            if (m_idle[k] == tmo_cfg[k]) begin
              fire = 1'b1;
              nxt = -1;
            end
          end
        end else if (!abort && word_ready) begin
          nxt = 0;
        end
        if (abort) nxt = -1;
        if (nxt <= 0 || nxt == W) m_idle[k] = 0;
        m_n[k] = nxt;
        m_to[k] = fire;
      end
    end
  end

  logic e_rdy, e_adv, e_wv;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_rdy = (m_n[k] >= 0) && (m_n[k] < W) && !abort;
      e_adv = e_rdy && in_valid;
      e_wv  = (m_n[k] == W) && !abort;
      chk("in_ready", k, in_ready[k], e_rdy);
      chk("sr_advance", k, sr_adv[k], e_adv);
      chk("sr_rst", k, sr_rst[k], m_n[k] < 0);
      chk("word_valid", k, word_valid[k], e_wv);
      chk("count", k, cnt[k], (m_n[k] < 0) ? 0 : m_n[k]);
      chk("timeout", k, tmo_pulse[k], m_to[k]);
      if (e_adv) chk("sr_bit", k, sr_bit[k], in_bit);
      if (e_wv) chk("word", k, word[k], m_word[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Present n bits MSB first from v (left aligned), one accept per cycle.
  task automatic send_bits(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit = v[W-1-i];
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [15:0] pat;
  int idx, nv, c1, c2;
  logic [W-1:0] w1, w2;
  bit acc;

  initial begin
    // Reset
    repeat (3) step();
    neg();
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", k, in_ready[k], 0);
      chk("rst_sr_rst", k, sr_rst[k], 1);
      chk("rst_word_valid", k, word_valid[k], 0);
      chk("rst_count", k, cnt[k], 0);
    end
    step();
    rst_n = 1'b1;
    neg();
    chk("clear_sr_rst", 0, sr_rst[0], 1);
    chk("clear_in_ready", 0, in_ready[0], 0);
    step();
    neg();
    chk("shift_in_ready", 0, in_ready[0], 1);
    chk("shift_count", 0, cnt[0], 0);

    // Basic word A5 followed by 5 cycles of backpressure
    step();
    word_ready = 1'b0;
    send_bits(8'hA5, 8);
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("bp_word", 0, word[0], 8'hA5);
      chk("bp_valid", 0, word_valid[0], 1);
      chk("bp_in_ready", 0, in_ready[0], 0);
      chk("bp_advance", 0, sr_adv[0], 0);
      chk("bp_count", 0, cnt[0], 8);
      step();
    end
    word_ready = 1'b1;
    neg();
    chk("bp_release_valid", 0, word_valid[0], 1);
    step();
    neg();
    chk("bp_after_ready", 0, in_ready[0], 1);
    chk("bp_after_count", 0, cnt[0], 0);

    // Abort after 3 bits, with a bit offered in the abort cycle
    step();
    send_bits(8'hE0, 3);
    abort = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b1;
    neg();
    chk("abort_in_ready", 0, in_ready[0], 0);
    chk("abort_advance", 0, sr_adv[0], 0);
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    neg();
    chk("abort_sr_rst", 0, sr_rst[0], 1);
    chk("abort_count", 0, cnt[0], 0);
    step();
    send_bits(8'h3C, 8);
    neg();
    chk("abort_word_valid", 0, word_valid[0], 1);
    chk("abort_word", 0, word[0], 8'h3C);
    step();

    // Idle timeout after 2 bits (TIMEOUT=4 instance only)
    send_bits(8'h80, 2);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("idle_no_pulse", 0, tmo_pulse[0], 0);
      chk("idle_count", 0, cnt[0], 2);
      step();
    end
    neg();
    chk("tmo_pulse", 0, tmo_pulse[0], 1);
    chk("tmo_sr_rst", 0, sr_rst[0], 1);
    chk("tmo_count", 0, cnt[0], 0);
    chk("tmo_off_pulse", 1, tmo_pulse[1], 0);
    chk("tmo_off_count", 1, cnt[1], 2);
    step();
    neg();
    chk("tmo_one_cycle", 0, tmo_pulse[0], 0);
    repeat (8) step();
    neg();
    chk("tmo_off_still", 1, cnt[1], 2);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // Timeout coinciding with abort
    send_bits(8'h40, 2);
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    neg();
    chk("tmo_abort_pulse", 0, tmo_pulse[0], 1);
    chk("tmo_abort_off", 1, tmo_pulse[1], 0);
    chk("tmo_abort_rst", 0, sr_rst[0], 1);
    chk("tmo_abort_rst", 1, sr_rst[1], 1);
    step();

    // Asynchronous reset mid-word
    send_bits(8'hD8, 5);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_in_ready", k, in_ready[k], 0);
      chk("arst_word_valid", k, word_valid[k], 0);
      chk("arst_sr_rst", k, sr_rst[k], 1);
      chk("arst_count", k, cnt[k], 0);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    send_bits(8'h81, 8);
    neg();
    for (int k = 0; k < 2; k++) begin
      chk("arst_word_valid2", k, word_valid[k], 1);
      chk("arst_word", k, word[k], 8'h81);
    end
    step();

    // Back-to-back FF then 00, continuous valid
    pat = 16'hFF00;
    idx = 0;
    nv = 0;
    c1 = -1;
    c2 = -1;
    w1 = 'x;
    w2 = 'x;
    for (int c = 0; c < 19; c++) begin
      in_valid = (idx < 16);
      in_bit = (idx < 16) ? pat[15-idx] : 1'b0;
      neg();
      if (word_valid[0]) begin
        nv++;
        if (nv == 1) begin c1 = c; w1 = word[0]; end
        else if (nv == 2) begin c2 = c; w2 = word[0]; end
      end
      acc = in_ready[0] && in_valid;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("b2b_nvalid", 0, nv, 2);
    chk("b2b_first_cycle", 0, c1, 8);
    chk("b2b_second_cycle", 0, c2, 17);
    chk("b2b_word_ff", 0, w1, 8'hFF);
    chk("b2b_word_00", 0, w2, 8'h00);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
